// File: rtl/cartpole_pkg.sv
// Shared types and constants for the CartPole episode driver.
package cartpole_pkg;

  localparam int unsigned CNT_W = 16;

  localparam logic [31:0] INIT_X_DEF         = 32'h0000_0000;
  localparam logic [31:0] INIT_X_DOT_DEF     = 32'h0000_0000;
  localparam logic [31:0] INIT_THETA_DEF     = 32'h0000_0000;
  localparam logic [31:0] INIT_THETA_DOT_DEF = 32'h0000_0000;

  // Galois form of x^32 + x^22 + x^2 + x + 1, shifting right.
  localparam logic [31:0] LFSR_SEED = 32'hACE1_2024;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OBS,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_e;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

  // Sign from the LFSR, exponent pinned to 2^-6, random mantissa.
  function automatic logic [31:0] lfsr_to_float(input logic [31:0] s);
    return {s[31], 8'h79, s[22:0]};
  endfunction

endpackage

// File: rtl/cartpole_episode_driver_if.sv
// Step-compute request/response bus between the episode driver (master) and the step-compute block (slave).
interface cartpole_episode_driver_if #(
  parameter int unsigned INPUT_BIT = 32
);
  logic                 o_signal;
  logic [INPUT_BIT-1:0] o_action;
  logic [INPUT_BIT-1:0] o_x;
  logic [INPUT_BIT-1:0] o_x_dot;
  logic [INPUT_BIT-1:0] o_float_theta;
  logic [INPUT_BIT-1:0] o_theta_dot;
  logic [INPUT_BIT-1:0] i_next_x;
  logic [INPUT_BIT-1:0] i_next_x_dot;
  logic [INPUT_BIT-1:0] i_next_float_theta;
  logic [INPUT_BIT-1:0] i_next_theta_dot;
  logic [INPUT_BIT-1:0] i_terminated;
  logic [INPUT_BIT-1:0] i_reward;
  logic [INPUT_BIT-1:0] i_valid;

  modport master (
    output o_signal, o_action, o_x, o_x_dot, o_float_theta, o_theta_dot,
    input  i_next_x, i_next_x_dot, i_next_float_theta, i_next_theta_dot,
    input  i_terminated, i_reward, i_valid
  );

  modport slave (
    input  o_signal, o_action, o_x, o_x_dot, o_float_theta, o_theta_dot,
    output i_next_x, i_next_x_dot, i_next_float_theta, i_next_theta_dot,
    output i_terminated, i_reward, i_valid
  );
endinterface

// File: rtl/cartpole_init_lfsr.sv
// Free-running 32-bit Galois LFSR supplying four consecutive init words.
// Only compiled when CARTPOLE_LFSR_INIT_EN is defined.
`ifdef CARTPOLE_LFSR_INIT_EN
module cartpole_init_lfsr
  import cartpole_pkg::*;
(
  input  logic             aclk,
  input  logic             aresetn,
  output logic [3:0][31:0] o_words
);
  logic [31:0] lfsr_q;
  logic [31:0] lfsr_d;
  logic [31:0] walk;

  always_comb begin
    lfsr_d = lfsr_next(lfsr_q);
  end

  always_comb begin
    o_words = '0;
    walk    = lfsr_q;
    for (int unsigned i = 0; i < 4; i++) begin
      o_words[i] = lfsr_to_float(walk);
      walk       = lfsr_next(walk);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) lfsr_q <= LFSR_SEED;
    else          lfsr_q <= lfsr_d;
  end
endmodule
`endif

// File: rtl/cartpole_episode_driver.sv
// CartPole episode driver: owns env state, sequences OBS/ISSUE/WAIT steps, counts steps/return.
// Define CARTPOLE_LFSR_INIT_EN to draw the initial state from an LFSR instead of INIT_*.
module cartpole_episode_driver
  import cartpole_pkg::*;
#(
  parameter int unsigned          INPUT_BIT      = 32,
  parameter int unsigned          MAX_STEPS      = 500,
  parameter int unsigned          TIMEOUT        = 1024,
  parameter logic [INPUT_BIT-1:0] INIT_X         = INPUT_BIT'(INIT_X_DEF),
  parameter logic [INPUT_BIT-1:0] INIT_X_DOT     = INPUT_BIT'(INIT_X_DOT_DEF),
  parameter logic [INPUT_BIT-1:0] INIT_THETA     = INPUT_BIT'(INIT_THETA_DEF),
  parameter logic [INPUT_BIT-1:0] INIT_THETA_DOT = INPUT_BIT'(INIT_THETA_DOT_DEF)
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 i_start,
  input  logic [INPUT_BIT-1:0] i_action,
  input  logic                 i_action_valid,
  output logic                 o_action_ready,
  output logic [INPUT_BIT-1:0] o_obs_x,
  output logic [INPUT_BIT-1:0] o_obs_x_dot,
  output logic [INPUT_BIT-1:0] o_obs_theta,
  output logic [INPUT_BIT-1:0] o_obs_theta_dot,
  output logic                 o_obs_valid,
  cartpole_episode_driver_if.master step,
  output logic [CNT_W-1:0]     o_step_count,
  output logic [CNT_W-1:0]     o_return,
  output logic                 o_episode_done,
  output logic                 o_truncated,
  output logic                 o_timeout,
  output logic                 o_busy
);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [INPUT_BIT-1:0] init_x, init_x_dot, init_theta, init_theta_dot;

`ifdef CARTPOLE_LFSR_INIT_EN
  localparam logic [INPUT_BIT-1:0] RST_WORD = INPUT_BIT'(lfsr_to_float(LFSR_SEED));
  localparam logic [INPUT_BIT-1:0] RST_X = RST_WORD, RST_X_DOT = RST_WORD;
  localparam logic [INPUT_BIT-1:0] RST_TH = RST_WORD, RST_TH_DOT = RST_WORD;
  logic [3:0][31:0] lfsr_words;

  cartpole_init_lfsr u_init_lfsr (
    .aclk    (aclk),
    .aresetn (aresetn),
    .o_words (lfsr_words)
  );

  assign init_x         = INPUT_BIT'(lfsr_words[0]);
  assign init_x_dot     = INPUT_BIT'(lfsr_words[1]);
  assign init_theta     = INPUT_BIT'(lfsr_words[2]);
  assign init_theta_dot = INPUT_BIT'(lfsr_words[3]);
`else
  localparam logic [INPUT_BIT-1:0] RST_X = INIT_X, RST_X_DOT = INIT_X_DOT;
  localparam logic [INPUT_BIT-1:0] RST_TH = INIT_THETA, RST_TH_DOT = INIT_THETA_DOT;

  assign init_x         = INIT_X;
  assign init_x_dot     = INIT_X_DOT;
  assign init_theta     = INIT_THETA;
  assign init_theta_dot = INIT_THETA_DOT;
`endif

  state_e               state_q, state_d;
  logic [INPUT_BIT-1:0] x_q, x_d, x_dot_q, x_dot_d, th_q, th_d, th_dot_q, th_dot_d;
  logic [INPUT_BIT-1:0] act_q, act_d;
  logic [CNT_W-1:0]     step_q, step_d, ret_q, ret_d, step_inc, ret_inc;
  logic [TW-1:0]        tmo_cnt_q, tmo_cnt_d, tmo_inc;
  logic                 trunc_q, trunc_d, tmo_q, tmo_d;
  logic                 obs_valid_q, obs_valid_d, signal_q, signal_d;
  logic                 done_q, done_d, busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    x_dot_d   = x_dot_q;
    th_d      = th_q;
    th_dot_d  = th_dot_q;
    act_d     = act_q;
    step_d    = step_q;
    ret_d     = ret_q;
    tmo_cnt_d = tmo_cnt_q;
    trunc_d   = trunc_q;
    tmo_d     = tmo_q;
    step_inc  = (step_q == '1) ? step_q : step_q + 1'b1;
    ret_inc   = (ret_q == '1) ? ret_q : ret_q + 1'b1;
    tmo_inc   = tmo_cnt_q + 1'b1;

    unique case (state_q)
      ST_IDLE: if (i_start) begin
        x_d       = init_x;
        x_dot_d   = init_x_dot;
        th_d      = init_theta;
        th_dot_d  = init_theta_dot;
        step_d    = '0;
        ret_d     = '0;
        tmo_cnt_d = '0;
        trunc_d   = 1'b0;
        tmo_d     = 1'b0;
        state_d   = ST_OBS;
      end
      ST_OBS: if (i_action_valid) begin
        act_d   = i_action;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        tmo_cnt_d = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        // A response arriving on the timeout cycle still counts as a normal step.
        if (step.i_valid[0]) begin
          x_d      = step.i_next_x;
          x_dot_d  = step.i_next_x_dot;
          th_d     = step.i_next_float_theta;
          th_dot_d = step.i_next_theta_dot;
          step_d   = step_inc;
          if (step.i_reward != '0) ret_d = ret_inc;
          if (step.i_terminated[0]) begin
            state_d = ST_DONE;
          end else if (step_inc == CNT_W'(MAX_STEPS)) begin
            trunc_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_OBS;
          end
        end else begin
          tmo_cnt_d = tmo_inc;
          if (tmo_inc == TW'(TIMEOUT)) begin
            tmo_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    obs_valid_d = (state_d == ST_OBS);
    signal_d    = (state_d == ST_ISSUE);
    done_d      = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      x_q         <= RST_X;
      x_dot_q     <= RST_X_DOT;
      th_q        <= RST_TH;
      th_dot_q    <= RST_TH_DOT;
      act_q       <= '0;
      step_q      <= '0;
      ret_q       <= '0;
      tmo_cnt_q   <= '0;
      trunc_q     <= 1'b0;
      tmo_q       <= 1'b0;
      obs_valid_q <= 1'b0;
      signal_q    <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      x_dot_q     <= x_dot_d;
      th_q        <= th_d;
      th_dot_q    <= th_dot_d;
      act_q       <= act_d;
      step_q      <= step_d;
      ret_q       <= ret_d;
      tmo_cnt_q   <= tmo_cnt_d;
      trunc_q     <= trunc_d;
      tmo_q       <= tmo_d;
      obs_valid_q <= obs_valid_d;
      signal_q    <= signal_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign o_action_ready     = obs_valid_q;
  assign o_obs_valid        = obs_valid_q;
  assign o_obs_x            = x_q;
  assign o_obs_x_dot        = x_dot_q;
  assign o_obs_theta        = th_q;
  assign o_obs_theta_dot    = th_dot_q;
  assign step.o_signal      = signal_q;
  assign step.o_action      = act_q;
  assign step.o_x           = x_q;
  assign step.o_x_dot       = x_dot_q;
  assign step.o_float_theta = th_q;
  assign step.o_theta_dot   = th_dot_q;
  assign o_step_count       = step_q;
  assign o_return           = ret_q;
  assign o_episode_done     = done_q;
  assign o_truncated        = trunc_q;
  assign o_timeout          = tmo_q;
  assign o_busy             = busy_q;

endmodule
